param_fetch: RTL

Operand fetch stage of the bytecode decoder. It sits directly downstream of the operand-count decoder. When a new opcode is accepted, it takes the decoded operand byte count and the opcode's instruction-RAM address. It then issues that many sequential IRAM reads and assembles the returned bytes big-endian into one parameter word. It reports the raw parameter, a sign-extended copy and the next-instruction address to the translation state machine.

---
 rtl/param_fetch_pkg.sv | 27 ++
 rtl/me_consts.vh | 16 +
 rtl/param_sext.sv | 30 +++
 rtl/param_fetch.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/param_fetch_pkg.sv
// rtl/param_fetch_pkg.sv - types and constants shared by the operand fetch stage
//
// Purpose: state enum for the fetch FSM and the widths used by param_fetch and
// param_sext. Encodings come from me_consts.vh so other decoder blocks agree.
`include "me_consts.vh"

package param_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = `PF_IDLE,
    ST_FETCH = `PF_FETCH,
    ST_FLUSH = `PF_FLUSH
  } pf_state_e;

  localparam int PF_COUNT_W   = `PARAM_LEN;
  localparam int PF_MAX_BYTES = `MAX_PARAM_BYTES;
  localparam int PF_WORD_W    = 32;

  // Append one big-endian byte to the low end of the assembled word.
  function automatic logic [PF_WORD_W-1:0] shift_in_byte(
    input logic [PF_WORD_W-1:0] word,
    input logic [7:0]           b
  );
    return {word[PF_WORD_W-9:0], b};
  endfunction

endpackage

// File: rtl/me_consts.vh
// rtl/me_consts.vh - shared decoder constants: operand length width, max operand bytes, fetch FSM encodings
`ifndef ME_CONSTS_VH
`define ME_CONSTS_VH

// Width of the decoded operand byte count (must hold counts above the legal maximum).
`define PARAM_LEN 3

// Largest legal operand byte count.
`define MAX_PARAM_BYTES 4

// Operand fetch FSM state encodings.
`define PF_IDLE  2'd0
`define PF_FETCH 2'd1
`define PF_FLUSH 2'd2

`endif

// File: rtl/param_sext.sv
// rtl/param_sext.sv - combinational sign extension of a 32-bit word by byte count
//
// Purpose: sign-extends word_i from bit 8*nbytes_i-1. A count of 0 (or any
// count outside 1..4) yields 0. Shared with the branch-offset logic.
// Ports:
//   word_i    in  32       zero-extended operand word
//   nbytes_i  in  COUNT_W  number of significant bytes
//   sext_o    out 32       sign-extended word
module param_sext
  import param_fetch_pkg::*;
#(
  parameter int COUNT_W = PF_COUNT_W
) (
  input  logic [PF_WORD_W-1:0] word_i,
  input  logic [COUNT_W-1:0]   nbytes_i,
  output logic [PF_WORD_W-1:0] sext_o
);

  always_comb begin
    sext_o = '0;
    case (nbytes_i)
      COUNT_W'(1): sext_o = {{24{word_i[7]}},  word_i[7:0]};
      COUNT_W'(2): sext_o = {{16{word_i[15]}}, word_i[15:0]};
      COUNT_W'(3): sext_o = {{8{word_i[23]}},  word_i[23:0]};
      COUNT_W'(4): sext_o = word_i;
      default:     sext_o = '0;
    endcase
  end

endmodule

// File: rtl/param_fetch.sv
// rtl/param_fetch.sv - operand fetch stage: sequential IRAM reads assembled into a parameter word
//
// Purpose: on an accepted opcode, issue `count` sequential reads starting just
// after the opcode, assemble the returned bytes big-endian, and report the raw
// word, its sign extension and the next-instruction address.
// Ports:
//   clk, reset          clock, async active-high reset
//   start               opcode accepted (count/opcode_addr valid)
//   count, opcode_addr  operand byte count and opcode IRAM address
//   iram_rd, iram_addr  IRAM read strobe/address (registered)
//   iram_data           IRAM read data, 1-cycle latency
//   busy, done, err     status; done/err are one-cycle pulses
//   param, sext         assembled word and its sign extension
//   param_len, next_pc  latched count and address following the operands
`include "me_consts.vh"

module param_fetch
  import param_fetch_pkg::*;
#(
  parameter int COUNT_W   = `PARAM_LEN,
  parameter int ADDR_W    = 16,
  parameter int MAX_BYTES = `MAX_PARAM_BYTES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [COUNT_W-1:0]   count,
  input  logic [ADDR_W-1:0]    opcode_addr,
  output logic                 iram_rd,
  output logic [ADDR_W-1:0]    iram_addr,
  input  logic [7:0]           iram_data,
  output logic                 busy,
  output logic                 done,
  output logic [PF_WORD_W-1:0] param,
  output logic [PF_WORD_W-1:0] sext,
  output logic [COUNT_W-1:0]   param_len,
  output logic [ADDR_W-1:0]    next_pc,
  output logic                 err
);

  localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_BYTES);

  pf_state_e              state_q, state_d;
  logic [ADDR_W-1:0]      ptr_q, ptr_d;
  logic [COUNT_W-1:0]     remain_q, remain_d;
  logic                   first_q, first_d;
  logic [PF_WORD_W-1:0]   param_q, param_d;
  logic [COUNT_W-1:0]     len_q, len_d;
  logic [ADDR_W-1:0]      npc_q, npc_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      remain_q <= '0;
      first_q  <= 1'b0;
      param_q  <= '0;
      len_q    <= '0;
      npc_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      remain_q <= remain_d;
      first_q  <= first_d;
      param_q  <= param_d;
      len_q    <= len_d;
      npc_q    <= npc_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    remain_d = remain_q;
    first_d  = first_q;
    param_d  = param_q;
    len_d    = len_q;
    npc_d    = npc_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count == '0) begin
            // No operands: complete immediately without touching IRAM.
            done_d  = 1'b1;
            param_d = '0;
            len_d   = '0;
            npc_d   = opcode_addr + ADDR_W'(1);
          end else if (count > MAX_CNT) begin
            // Illegal count: flag it and leave every result untouched.
            err_d = 1'b1;
          end else begin
            len_d    = count;
            param_d  = '0;
            ptr_d    = opcode_addr + ADDR_W'(1);
            remain_d = count;
            first_d  = 1'b1;
            state_d  = ST_FETCH;
          end
        end
      end

      ST_FETCH: begin
        ptr_d    = ptr_q + ADDR_W'(1);
        remain_d = remain_q - COUNT_W'(1);
        first_d  = 1'b0;
        // RAM latency is one cycle, so the first FETCH cycle has no data yet.
        if (!first_q) begin
          param_d = shift_in_byte(param_q, iram_data);
        end
        if (remain_q == COUNT_W'(1)) begin
          state_d = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        param_d = shift_in_byte(param_q, iram_data);
        // The pointer has advanced past the last operand byte: that is next_pc.
        npc_d   = ptr_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  param_sext #(
    .COUNT_W (COUNT_W)
  ) u_sext (
    .word_i   (param_q),
    .nbytes_i (len_q),
    .sext_o   (sext)
  );

  assign iram_rd   = (state_q == ST_FETCH);
  assign iram_addr = ptr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign param     = param_q;
  assign param_len = len_q;
  assign next_pc   = npc_q;

endmodule
